// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: funct3 codes, FSM states,
// lane/byte-enable helpers and the default bus timeout.
package lsu_pkg;

  localparam int LSU_TIMEOUT_DEFAULT = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Narrow stores replicate their lane so the slave can pick it by byte enable alone.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction with sign/zero extension for the load/store unit.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_bus_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'b00:   w_byte = i_bus_rdata[7:0];
      2'b01:   w_byte = i_bus_rdata[15:8];
      2'b10:   w_byte = i_bus_rdata[23:16];
      2'b11:   w_byte = i_bus_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_bus_rdata[31:16];
    end else begin
      w_half = i_bus_rdata[15:0];
    end
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_bus_rdata;
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> BUS -> DONE handshake to a simple bus.
// Optional bus timeout abort is enabled with macro LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_out,
  output logic        stall,
  output logic        lsu_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  r_state, w_next_state;
  logic [31:0] r_rdata, r_bus_addr, r_bus_wdata, w_load_data;
  logic [3:0]  r_bus_be;
  logic        r_bus_we;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        w_req, w_accept, w_reject, w_done_fault, w_tmo_hit;

  assign w_req    = mem_read | mem_write;
  assign w_accept = w_req & f3_legal(mem_write, funct3) & ~is_misaligned(funct3[1:0], addr[1:0]);
  assign w_reject = w_req & ~w_accept;

  assign rdata_out = r_rdata;
  assign bus_req   = (r_state == BUS);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

  lsu_load_align u_align (
    .i_bus_rdata (bus_rdata),
    .i_addr_lo   (r_off),
    .i_funct3    (r_funct3),
    .o_data      (w_load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;
  logic          r_timeout;

  assign w_tmo_hit    = (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_done_fault = r_timeout;

  // Count unacknowledged BUS cycles; ack on the final edge wins over timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == BUS && !bus_ack) begin
      r_tmo_cnt <= r_tmo_cnt + CW'(1);
      r_timeout <= w_tmo_hit;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo_hit    = 1'b0;
  assign w_done_fault = 1'b0;
`endif

  // Next state plus combinational stall/fault.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    lsu_fault    = 1'b0;
    case (r_state)
      IDLE: begin
        stall     = w_accept;
        lsu_fault = w_reject;
        if (w_accept) begin
          w_next_state = BUS;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUS: begin
        stall = 1'b1;
        if (bus_ack || w_tmo_hit) begin
          w_next_state = DONE;
        end else begin
          w_next_state = BUS;
        end
      end
      DONE: begin
        lsu_fault    = w_done_fault;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, captured request and load result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rdata     <= 32'h0000_0000;
      r_bus_addr  <= 32'h0000_0000;
      r_bus_wdata <= 32'h0000_0000;
      r_bus_be    <= 4'b0000;
      r_bus_we    <= 1'b0;
      r_off       <= 2'b00;
      r_funct3    <= 3'b000;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_accept) begin
        r_bus_addr  <= {addr[31:2], 2'b00};
        r_bus_we    <= mem_write;
        r_bus_be    <= byte_en(funct3[1:0], addr[1:0]);
        r_bus_wdata <= store_data(funct3[1:0], wdata);
        r_off       <= addr[1:0];
        r_funct3    <= funct3;
      end
      if (r_state == BUS && bus_ack && !r_bus_we) begin
        r_rdata <= w_load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout vector only with LSU_TIMEOUT_EN).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata_out, bus_addr, bus_wdata, bus_rdata;
  logic        stall, lsu_fault, bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata_out (rdata_out),
    .stall     (stall),
    .lsu_fault (lsu_fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full access from IDLE; called on a negedge, returns on a negedge back in IDLE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int ack_wait,
                            input logic [3:0] exp_be, input logic [31:0] exp_addr,
                            input logic chk_wd, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rdata);
    int stall_cnt;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    stall_cnt = stall ? 1 : 0;
    check_val({tag, " no_fault"}, {31'd0, lsu_fault}, 32'd0);
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    funct3 = 3'b111;
    #1;
    check_val({tag, " bus_req"}, {31'd0, bus_req}, 32'd1);
    check_val({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
    check_val({tag, " bus_addr"}, bus_addr, exp_addr);
    check_val({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, wr});
    if (chk_wd) check_val({tag, " bus_wdata"}, bus_wdata, exp_wd);
    for (int i = 0; i < ack_wait; i++) begin
      if (stall) stall_cnt++;
      next_cycle();
      #1;
    end
    bus_rdata = rdat; bus_ack = 1'b1;
    #1;
    if (stall) stall_cnt++;
    next_cycle();
    bus_ack = 1'b0; bus_rdata = 32'hA5A5_5A5A;
    #1;
    check_val({tag, " done_req"}, {31'd0, bus_req}, 32'd0);
    check_val({tag, " done_stall"}, {31'd0, stall}, 32'd0);
    check_val({tag, " stall_cycles"}, 32'(stall_cnt), 32'(2 + ack_wait));
    check_val({tag, " rdata_out"}, rdata_out, exp_rdata);
    next_cycle();
  endtask

  // Rejected request: fault same cycle, no stall, no bus cycle afterwards.
  task automatic run_fault(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    #1;
    check_val({tag, " fault"}, {31'd0, lsu_fault}, 32'd1);
    check_val({tag, " stall"}, {31'd0, stall}, 32'd0);
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_val({tag, " bus_req"}, {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    next_cycle();
    next_cycle();
    check_val("rst rdata_out", rdata_out, 32'd0);
    check_val("rst bus_req", {31'd0, bus_req}, 32'd0);
    check_val("rst bus_we", {31'd0, bus_we}, 32'd0);
    check_val("rst bus_be", {28'd0, bus_be}, 32'd0);
    check_val("rst bus_addr", bus_addr, 32'd0);
    check_val("rst bus_wdata", bus_wdata, 32'd0);
    check_val("rst stall", {31'd0, stall}, 32'd0);
    check_val("rst fault", {31'd0, lsu_fault}, 32'd0);
    reset = 1'b0;
    next_cycle();

    run_access("lw", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0,
               4'b1111, 32'h0000_0100, 1'b0, 32'h0, 32'hDEAD_BEEF);
    run_access("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0,
               4'b1000, 32'h0000_0100, 1'b0, 32'h0, 32'hFFFF_FF80);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 0,
               4'b1000, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0080);
    run_access("lh_wait", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_1234, 2,
               4'b1100, 32'h0000_0100, 1'b0, 32'h0, 32'hFFFF_8001);
    run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_F00D, 0,
               4'b0011, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_F00D);
    run_access("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_1111, 0,
               4'b1100, 32'h0000_0200, 1'b1, 32'hABCD_ABCD, 32'h0000_F00D);
    run_access("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 32'h2222_2222, 1,
               4'b0010, 32'h0000_0200, 1'b1, 32'hA5A5_A5A5, 32'h0000_F00D);
    run_access("rw_sw", 1'b1, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h3333_3333, 0,
               4'b1111, 32'h0000_0204, 1'b1, 32'hCAFE_F00D, 32'h0000_F00D);
    run_access("lb_lane1", 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00, 1,
               4'b0010, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_007F);

    run_fault("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101);
    run_fault("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0103);
    run_fault("sw_mis", 1'b0, 1'b1, 3'b010, 32'h0000_0202);
    run_fault("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
    run_fault("ld_f3_110", 1'b1, 1'b0, 3'b110, 32'h0000_0100);
    run_fault("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0100);

    // Ack in IDLE is ignored.
    bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
    next_cycle();
    bus_ack = 1'b0;
    #1;
    check_val("idle_ack rdata", rdata_out, 32'h0000_007F);
    check_val("idle_ack req", {31'd0, bus_req}, 32'd0);

    // Request presented during DONE is ignored.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
    next_cycle();
    mem_read = 1'b0;
    bus_rdata = 32'h0BAD_F00D; bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0; mem_read = 1'b1; addr = 32'h0000_0300;
    #1;
    check_val("done_ign stall", {31'd0, stall}, 32'd0);
    check_val("done_ign rdata", rdata_out, 32'h0BAD_F00D);
    next_cycle();
    mem_read = 1'b0;
    #1;
    check_val("done_ign req", {31'd0, bus_req}, 32'd0);
    next_cycle();

    // Reset in the second BUS cycle abandons the access.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
    next_cycle();
    mem_read = 1'b0;
    next_cycle();
    #1;
    check_val("rstbus pre_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    #1;
    check_val("rstbus req", {31'd0, bus_req}, 32'd0);
    check_val("rstbus stall", {31'd0, stall}, 32'd0);
    check_val("rstbus rdata", rdata_out, 32'd0);
    next_cycle();
    bus_ack = 1'b0;
    #1;
    check_val("rstbus late_ack req", {31'd0, bus_req}, 32'd0);
    check_val("rstbus late_ack rdata", rdata_out, 32'd0);
    next_cycle();

`ifdef LSU_TIMEOUT_EN
    begin
      int req_cycles;
      run_access("tmo_pre", 1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_0042, 0,
                 4'b0001, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0042);
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
      next_cycle();
      mem_read = 1'b0;
      req_cycles = 0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (!bus_req) break;
        req_cycles++;
        next_cycle();
      end
      check_val("tmo bus_cycles", 32'(req_cycles), 32'd4);
      check_val("tmo fault", {31'd0, lsu_fault}, 32'd1);
      check_val("tmo stall", {31'd0, stall}, 32'd0);
      next_cycle();
      #1;
      check_val("tmo fault_pulse", {31'd0, lsu_fault}, 32'd0);
      check_val("tmo rdata", rdata_out, 32'h0000_0042);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
